wshb_arbiter: RTL and testbench

WSHB_ARBITER -- requirements
Module: wshb_arbiter

---
 rtl/wshb_arb_pkg.sv | 13 +
 rtl/wshb_arb_mux.sv | 70 +++++++
 rtl/wshb_arbiter.sv | 149 ++++++++++++++
 tb/tb_wshb_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wshb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter in front of the SDRAM slave.
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } arb_state_t;

  // Beats acknowledged in the current grant tenure; saturates at MAX_BURST.
  typedef logic [7:0] beat_t;

endpackage

// File: rtl/wshb_arb_mux.sv
// Grant-indexed steering of master requests onto the slave port, and ack demux
// back to whichever master holds the grant. Read data fans out unconditionally.
module wshb_arb_mux #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic [1:0]      gnt,
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat_ms,
  input  logic [DW/8-1:0] m0_sel,
  output logic            m0_ack,
  output logic [DW-1:0]   m0_dat_sm,
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat_ms,
  input  logic [DW/8-1:0] m1_sel,
  output logic            m1_ack,
  output logic [DW-1:0]   m1_dat_sm,
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_ms,
  output logic [DW/8-1:0] s_sel,
  input  logic            s_ack,
  input  logic [DW-1:0]   s_dat_sm
);

  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

  // Route the granted master to the slave; with no grant the bus is quiet and acks are dropped.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (gnt)
      2'b01: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        m0_ack   = s_ack;
      end
      2'b10: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        m1_ack   = s_ack;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter (m0 video reader, m1 pattern writer) onto one SDRAM slave.
// An owner may be preempted once it has completed MAX_BURST beats, only at a beat
// boundary (s_ack, or strobe low) so no pending transfer is dropped.
// Build option WSHB_ARB_RR_EN: round-robin tie-break and preemption of either master.
// Without it, m0 wins ties, holds the bus for as long as m0_cyc is high, and only m1
// can be preempted.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat_ms,
  input  logic [DW/8-1:0] m0_sel,
  output logic            m0_ack,
  output logic [DW-1:0]   m0_dat_sm,
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat_ms,
  input  logic [DW/8-1:0] m1_sel,
  output logic            m1_ack,
  output logic [DW-1:0]   m1_dat_sm,
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_ms,
  output logic [DW/8-1:0] s_sel,
  input  logic            s_ack,
  input  logic [DW-1:0]   s_dat_sm,
  output logic [1:0]      gnt
);

`ifdef WSHB_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  localparam beat_t MAX_B = beat_t'(MAX_BURST);

  function automatic beat_t beat_sat_inc(input beat_t b);
    return (b >= MAX_B) ? MAX_B : b + 8'd1;
  endfunction

  arb_state_t state;
  arb_state_t state_next;
  beat_t      beat;
  beat_t      beat_now;
  logic       last_gnt;
  logic       req0;
  logic       req1;
  logic       burst_done;

  assign req0       = m0_cyc & m0_stb;
  assign req1       = m1_cyc & m1_stb;
  // Count including an ack landing this cycle, so preemption can happen on the MAX_BURST-th ack edge.
  assign beat_now   = (s_ack && state != IDLE) ? beat_sat_inc(beat) : beat;
  assign burst_done = (beat_now == MAX_B);

  // Grant selection: tie-break in IDLE, release on cyc drop, preempt at a beat boundary.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_next = (RR_EN && !last_gnt) ? G1 : G0;
        else if (req0)     state_next = G0;
        else if (req1)     state_next = G1;
      end
      G0: begin
        if (!m0_cyc)       state_next = req1 ? G1 : IDLE;
        else if (RR_EN && req1 && burst_done && (s_ack || !m0_stb))
                           state_next = G1;
      end
      G1: begin
        if (!m1_cyc)       state_next = req0 ? G0 : IDLE;
        else if (req0 && burst_done && (s_ack || !m1_stb))
                           state_next = G0;
      end
      default:             state_next = IDLE;
    endcase
  end

  // State, tenure beat count (cleared on every grant change) and last-granted master.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat     <= '0;
      last_gnt <= 1'b1;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        beat <= '0;
        if (state_next == G0)      last_gnt <= 1'b0;
        else if (state_next == G1) last_gnt <= 1'b1;
      end else begin
        beat <= beat_now;
      end
    end
  end

  // One-hot grant straight from the state register.
  always_comb begin
    gnt = 2'b00;
    case (state)
      G0:      gnt = 2'b01;
      G1:      gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  wshb_arb_mux #(.AW(AW), .DW(DW)) u_mux (
    .gnt       (gnt),
    .m0_cyc    (m0_cyc),
    .m0_stb    (m0_stb),
    .m0_we     (m0_we),
    .m0_adr    (m0_adr),
    .m0_dat_ms (m0_dat_ms),
    .m0_sel    (m0_sel),
    .m0_ack    (m0_ack),
    .m0_dat_sm (m0_dat_sm),
    .m1_cyc    (m1_cyc),
    .m1_stb    (m1_stb),
    .m1_we     (m1_we),
    .m1_adr    (m1_adr),
    .m1_dat_ms (m1_dat_ms),
    .m1_sel    (m1_sel),
    .m1_ack    (m1_ack),
    .m1_dat_sm (m1_dat_sm),
    .s_cyc     (s_cyc),
    .s_stb     (s_stb),
    .s_we      (s_we),
    .s_adr     (s_adr),
    .s_dat_ms  (s_dat_ms),
    .s_sel     (s_sel),
    .s_ack     (s_ack),
    .s_dat_sm  (s_dat_sm)
  );

endmodule

// File: tb/tb_wshb_arbiter.sv
// Bench for wshb_arbiter: behavioural owner/tenure model compared every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_wshb_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXB = 16;
`ifdef WSHB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0]   m0_adr, m1_adr, s_adr;
  logic [DW-1:0]   m0_dat_ms, m1_dat_ms, s_dat_ms, s_dat_sm, m0_dat_sm, m1_dat_sm;
  logic [DW/8-1:0] m0_sel, m1_sel, s_sel;
  logic            m0_ack, m1_ack, s_cyc, s_stb, s_we, s_ack;
  logic [1:0]      gnt;

  always #5 clk = ~clk;

  wshb_arbiter #(.MAX_BURST(MAXB), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_ack(s_ack), .s_dat_sm(s_dat_sm),
    .gnt(gnt)
  );

  int checks = 0;
  int errors = 0;

  // Model: owner is -1 (nobody), 0 or 1; tenure counts acks since the grant began (unbounded).
  int mdl_own    = -1;
  int mdl_tenure = 0;
  int mdl_last   = 1;

  always @(posedge clk or negedge rst_n) begin : model_b
    int nxt, oth, acks;
    bit r0, r1, ocyc, ostb, oreq, can_pre;
    if (!rst_n) begin
      mdl_own    <= -1;
      mdl_tenure <= 0;
      mdl_last   <= 1;
    end else begin
      r0  = m0_cyc && m0_stb;
      r1  = m1_cyc && m1_stb;
      nxt = mdl_own;
      if (mdl_own < 0) begin
        if (r0 && r1)  nxt = (RR && mdl_last == 0) ? 1 : 0;
        else if (r0)   nxt = 0;
        else if (r1)   nxt = 1;
      end else begin
        oth     = 1 - mdl_own;
        ocyc    = (mdl_own == 0) ? m0_cyc : m1_cyc;
        ostb    = (mdl_own == 0) ? m0_stb : m1_stb;
        oreq    = (oth == 0) ? r0 : r1;
        acks    = mdl_tenure + (s_ack ? 1 : 0);
        can_pre = RR || (mdl_own == 1);
        if (!ocyc)
          nxt = oreq ? oth : -1;
        else if (can_pre && oreq && acks >= MAXB && (s_ack || !ostb))
          nxt = oth;
      end
      if (nxt != mdl_own) begin
        mdl_tenure <= 0;
        if (nxt >= 0) mdl_last <= nxt;
      end else if (mdl_own >= 0 && s_ack) begin
        mdl_tenure <= mdl_tenure + 1;
      end
      mdl_own <= nxt;
    end
  end

  logic [1:0] smp_gnt;
  logic       smp_a0, smp_a1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model's owner.
  task automatic cmp_cycle();
    logic [138:0] a, e;
    smp_gnt = gnt;
    smp_a0  = m0_ack;
    smp_a1  = m1_ack;
    a = {gnt, s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel, m0_ack, m1_ack, m0_dat_sm, m1_dat_sm};
    case (mdl_own)
      0:       e = {2'b01, m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_ms, m0_sel, s_ack, 1'b0, s_dat_sm, s_dat_sm};
      1:       e = {2'b10, m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_ms, m1_sel, 1'b0, s_ack, s_dat_sm, s_dat_sm};
      default: e = {2'b00, 3'b000, {AW{1'b0}}, {DW{1'b0}}, {(DW/8){1'b0}}, 2'b00, s_dat_sm, s_dat_sm};
    endcase
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cycle_cmp own=%0d: got %h expected %h at %0t", mdl_own, a, e, $time);
    end
  endtask

  // Compare at the falling edge, then return just after the next rising edge for new stimulus.
  task automatic step();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_ms = '0; m0_sel = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_ms = '0; m1_sel = '0;
    s_ack = 0; s_dat_sm = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic set_req(input int m, input bit v);
    if (m == 0) begin
      m0_cyc = v; m0_stb = v; m0_adr = 32'h0000_1000; m0_dat_ms = 32'hA0A0_0000; m0_sel = 4'hF;
    end else begin
      m1_cyc = v; m1_stb = v; m1_we = v; m1_adr = 32'h0000_2000; m1_dat_ms = 32'hB1B1_0000; m1_sel = 4'h3;
    end
  endtask

  initial begin : main
    int n0, n1, bad, f, r0, r1, owner, oth, cnt, hold;
    bit a0s [0:99];
    bit a1s [0:99];

    idle_inputs();
    rst_n = 0;
    @(posedge clk);
    #1;
    step();
    step();
    rst_n = 1;
    chk("reset_gnt", gnt, 2'b00);
    chk("reset_stb", s_stb, 1'b0);

    // Reset in the middle of an m1 transfer, then both requesting after release.
    set_req(1, 1);
    step();
    chk("g1_grant", gnt, 2'b10);
    s_ack = 1;
    step();
    set_req(0, 1);
    #2;
    rst_n = 0;
    #1;
    chk("rst_mid_gnt", gnt, 2'b00);
    chk("rst_mid_stb", s_stb, 1'b0);
    chk("rst_mid_ack", {m0_ack, m1_ack}, 2'b00);
    step();
    rst_n = 1;
    step();
    chk("post_rst_gnt", gnt, 2'b01);
    chk("post_rst_model", mdl_own, 0);

    // Lone m1, slave acking every cycle for 40 beats: no preemption.
    do_reset();
    set_req(1, 1);
    step();
    chk("solo_grant", gnt, 2'b10);
    s_ack = 1;
    n1 = 0; bad = 0;
    repeat (40) begin
      step();
      n1 += smp_a1;
      if (smp_gnt != 2'b10) bad++;
    end
    chk("solo_acks", n1, 40);
    chk("solo_hold", bad, 0);

    // m0 streaming, m1 joins after m0's third ack.
    do_reset();
    set_req(0, 1);
    s_ack = 1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      a0s[i] = smp_a0;
      a1s[i] = smp_a1;
      n0 += smp_a0;
      n1 += smp_a1;
      if (n0 == 3) set_req(1, 1);
    end
`ifdef WSHB_ARB_RR_EN
    f = 0;
    while (f < 99 && !a1s[f]) f++;
    r0 = 0;
    for (int i = 0; i < f; i++) r0 += a0s[i];
    r1 = 0;
    while (f + r1 < 99 && a1s[f + r1]) r1++;
    chk("rr_m0_beats", r0, 16);
    chk("rr_m1_beats", r1, 16);
    chk("rr_back_to_m0", a0s[f + r1], 1'b1);
`else
    chk("fixed_m1_starved", n1, 0);
    chk("fixed_m0_beats", n0, 99);
    chk("fixed_m0_gnt", gnt, 2'b01);
`endif

    // Preemption point with the slave ack held off for 5 cycles.
    owner = RR ? 0 : 1;
    oth   = 1 - owner;
    do_reset();
    set_req(owner, 1);
    step();
    s_ack = 1;
    cnt = 0;
    repeat (15) begin
      step();
      cnt += (owner == 0) ? smp_a0 : smp_a1;
    end
    set_req(oth, 1);
    s_ack = 0;
    hold = 0;
    repeat (5) begin
      step();
      if (smp_gnt == ((owner == 0) ? 2'b01 : 2'b10)) hold++;
      cnt += (owner == 0) ? smp_a0 : smp_a1;
    end
    s_ack = 1;
    step();
    cnt += (owner == 0) ? smp_a0 : smp_a1;
    chk("delay_hold", hold, 5);
    chk("delay_owner_acks", cnt, 16);
    chk("delay_switch_gnt", gnt, (oth == 0) ? 2'b01 : 2'b10);
    chk("delay_switch_model", mdl_own, oth);

    // Slave acks while idle must not reach either master.
    do_reset();
    s_ack = 1;
    bad = 0;
    repeat (4) begin
      step();
      bad += smp_a0 + smp_a1;
    end
    chk("idle_acks", bad, 0);
    chk("idle_gnt", gnt, 2'b00);

    // Randomized traffic with long-held cycles so bursts reach the preemption limit.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (m0_cyc) m0_cyc = ($urandom_range(39) != 0);
      else        m0_cyc = ($urandom_range(3) == 0);
      if (m1_cyc) m1_cyc = ($urandom_range(39) != 0);
      else        m1_cyc = ($urandom_range(3) == 0);
      m0_stb    = m0_cyc & ($urandom_range(3) != 0);
      m1_stb    = m1_cyc & ($urandom_range(3) != 0);
      m0_we     = $urandom_range(1);
      m1_we     = $urandom_range(1);
      m0_adr    = $urandom;
      m1_adr    = $urandom;
      m0_dat_ms = $urandom;
      m1_dat_ms = $urandom;
      m0_sel    = 4'($urandom);
      m1_sel    = 4'($urandom);
      s_ack     = $urandom_range(1);
      s_dat_sm  = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
